word_gen_outbuf: RTL and testbench
==================================

// Module: word_gen_outbuf
// PURPOSE
//  Output stage directly downstream of the word generator.
//  - Drains generated candidates through the generator's rd_en/empty interface into a DEPTH-entry FIFO.
//  - Presents them to the crypt-core distributor over a valid/ready handshake.
//  - Counts the candidates accepted per packet. When the packet's last (gen_end) word is accepted,
//    emits one report {pkt_id, num_cand} for the pkt_comm output path.
// PARAMETERS
//  CHAR_BITS     7  bits per character (7 or 8)
//  WORD_MAX_LEN  8  characters per word
//  DEPTH         4  FIFO entries; power of 2, >= 2
// PORTS
//  CLK          in   1        single clock (same domain as generator output)
//  rst_n        in   1        synchronous reset, active low
//  gen_dout     in   W*CB     generated word (W=WORD_MAX_LEN, CB=CHAR_BITS)
//  gen_pkt_id   in   16       packet id of gen_dout
//  gen_word_id  in   16       source word id of gen_dout
//  gen_id       in   32       generation index of gen_dout
//  gen_end      in   1        gen_dout is the last word of its packet
//  gen_empty    in   1        generator has no word available
//  gen_rd_en    out  1        pop one word from generator
//  out_word     out  W*CB     candidate to distributor
//  out_pkt_id   out  16       packet id of out_word
//  out_word_id  out  16       word id of out_word
//  out_gen_id   out  32       gen_id of out_word
//  out_valid    out  1        out_* holds a valid candidate
//  out_ready    in   1        distributor accepts the candidate
//  rpt_valid    out  1        packet report pending
//  rpt_pkt_id   out  16       packet id being reported
//  rpt_num_cand out  32       candidates accepted for that packet
//  rpt_ready    in   1        report consumer accepts
// BEHAVIOUR
//  Reset (rst_n=0 at posedge CLK):
//   - FIFO pointers/count=0; out_valid=0; rpt_valid=0; rpt_pkt_id=0; rpt_num_cand=0; cand_cnt=0.
//   - gen_rd_en=0 while rst_n=0.
//   - Mid-operation reset discards FIFO contents and any pending report.
//  Input:
//   - gen_rd_en = rst_n & ~gen_empty & (fifo_cnt != DEPTH); purely combinational.
//   - The entry {gen_dout, gen_pkt_id, gen_word_id, gen_id, gen_end} is written on the same edge.
//   - A full FIFO blocks writes even if a read happens in that cycle. No bypass.
//  Output:
//   - out_valid = (fifo_cnt != 0) & ~stall. out_* are driven from the head entry.
//   - Latency: a word popped at edge t is visible on out_* after edge t (earliest acceptance at edge t+1).
//   - Accept = out_valid & out_ready; advances the head.
//   - out_* hold stable while out_valid & ~out_ready.
//   - Simultaneous write and accept keeps fifo_cnt unchanged. Pointers wrap modulo DEPTH.
//  Counting:
//   - cand_cnt (32 b) increments on each accept; saturates at 32'hFFFFFFFF.
//   - On accept of a head entry with gen_end=1:
//     * rpt_pkt_id <= head pkt_id; rpt_num_cand <= sat(cand_cnt+1); rpt_valid <= 1; cand_cnt <= 0.
//   - No report is produced for packets without a gen_end word.
//  Report FSM:
//   - RPT_IDLE --(gen_end accept)--> RPT_HOLD.
//   - RPT_HOLD --(rpt_ready)--> RPT_IDLE.
//   - RPT_HOLD with rpt_ready and a new gen_end accept in the same cycle: stay in RPT_HOLD and load the new report.
//   - rpt_* stable while rpt_valid & ~rpt_ready.
//  Stall:
//   - stall = head.gen_end & rpt_valid & ~rpt_ready.
//   - A second end-of-packet word is never accepted until the previous report is taken.
//   - Non-end words continue to flow while a report is pending.
//  Widths:
//   - fifo_cnt is log2(DEPTH)+1 bits; pointers are log2(DEPTH) bits.
// TESTING
//  1. gen_empty=0 with 3 words, gen_end on the 3rd; out_ready=1 -> out_valid from cycle 2, 3 accepts,
//     rpt_valid=1 with rpt_num_cand=3 and rpt_pkt_id=gen_pkt_id.
//  2. out_ready=0, 6 words offered, DEPTH=4 -> exactly 4 gen_rd_en pulses, out_* frozen on word 0;
//     on release, words 1..5 arrive in order.
//  3. Two packets (2 words then 1 word), rpt_ready=0 -> report #1 =2; 2nd pkt's end word stalled
//     (out_valid=0); after rpt_ready pulse -> report #2 =1.
//  4. rpt_ready=1 in the same cycle as a new gen_end accept -> old report consumed,
//     new report loaded, rpt_valid stays 1.
//  5. rst_n=0 for 1 cycle with FIFO holding 3 words and a report pending -> out_valid=0, rpt_valid=0,
//     next packet count restarts at 1.
//  6. Force cand_cnt to 32'hFFFFFFFE, accept 3 words (last gen_end) -> rpt_num_cand=32'hFFFFFFFF.

Source files
------------

// File: rtl/word_gen_outbuf_if.sv
// Handshake bundle between the word generator, this output buffer, the distributor
// and the packet report consumer.
interface word_gen_outbuf_if #(
  parameter int unsigned CHAR_BITS    = 7,
  parameter int unsigned WORD_MAX_LEN = 8
);
  localparam int unsigned W = CHAR_BITS * WORD_MAX_LEN;

  logic [W-1:0] gen_dout;
  logic [15:0]  gen_pkt_id;
  logic [15:0]  gen_word_id;
  logic [31:0]  gen_id;
  logic         gen_end;
  logic         gen_empty;
  logic         gen_rd_en;

  logic [W-1:0] out_word;
  logic [15:0]  out_pkt_id;
  logic [15:0]  out_word_id;
  logic [31:0]  out_gen_id;
  logic         out_valid;
  logic         out_ready;

  logic         rpt_valid;
  logic [15:0]  rpt_pkt_id;
  logic [31:0]  rpt_num_cand;
  logic         rpt_ready;

  // Environment side: generator, distributor and report consumer.
  modport master (
    output gen_dout, gen_pkt_id, gen_word_id, gen_id, gen_end, gen_empty,
    input  gen_rd_en,
    input  out_word, out_pkt_id, out_word_id, out_gen_id, out_valid,
    output out_ready,
    input  rpt_valid, rpt_pkt_id, rpt_num_cand,
    output rpt_ready
  );

  // Output buffer side.
  modport slave (
    input  gen_dout, gen_pkt_id, gen_word_id, gen_id, gen_end, gen_empty,
    output gen_rd_en,
    output out_word, out_pkt_id, out_word_id, out_gen_id, out_valid,
    input  out_ready,
    output rpt_valid, rpt_pkt_id, rpt_num_cand,
    input  rpt_ready
  );
endinterface

// File: rtl/word_gen_outbuf.sv
// Word generator output stage: FIFO between generator and distributor, plus per-packet
// candidate counting with a one-deep report holding register.
module word_gen_outbuf #(
  parameter int unsigned CHAR_BITS    = 7,
  parameter int unsigned WORD_MAX_LEN = 8,
  parameter int unsigned DEPTH        = 4
) (
  input logic              CLK,
  input logic              rst_n,
  word_gen_outbuf_if.slave bus
);
  localparam int unsigned W  = CHAR_BITS * WORD_MAX_LEN;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  typedef enum logic {RptIdle, RptHold} rpt_state_e;

  logic [W-1:0]     mem_word    [DEPTH];
  logic [15:0]      mem_pkt_id  [DEPTH];
  logic [15:0]      mem_word_id [DEPTH];
  logic [31:0]      mem_gen_id  [DEPTH];
  logic [DEPTH-1:0] mem_end;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic [31:0]   cand_cnt, cand_inc;

  rpt_state_e rpt_state;
  logic        rpt_valid_r;
  logic [15:0] rpt_pkt_id_r;
  logic [31:0] rpt_num_r;

  logic wr_en, accept, end_accept, stall, head_end, out_valid_c;

  assign wr_en         = rst_n & ~bus.gen_empty & (fifo_cnt != FullCnt);
  assign bus.gen_rd_en = wr_en;

  assign head_end    = mem_end[rd_ptr];
  // Hold an end-of-packet word back until the previous report has been taken.
  assign stall       = head_end & rpt_valid_r & ~bus.rpt_ready;
  assign out_valid_c = (fifo_cnt != '0) & ~stall;
  assign accept      = out_valid_c & bus.out_ready;
  assign end_accept  = accept & head_end;
  assign cand_inc    = (cand_cnt == '1) ? cand_cnt : cand_cnt + 32'd1;

  assign bus.out_valid   = out_valid_c;
  assign bus.out_word    = mem_word[rd_ptr];
  assign bus.out_pkt_id  = mem_pkt_id[rd_ptr];
  assign bus.out_word_id = mem_word_id[rd_ptr];
  assign bus.out_gen_id  = mem_gen_id[rd_ptr];

  assign bus.rpt_valid    = rpt_valid_r;
  assign bus.rpt_pkt_id   = rpt_pkt_id_r;
  assign bus.rpt_num_cand = rpt_num_r;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_word[wr_ptr]    <= bus.gen_dout;
      mem_pkt_id[wr_ptr]  <= bus.gen_pkt_id;
      mem_word_id[wr_ptr] <= bus.gen_word_id;
      mem_gen_id[wr_ptr]  <= bus.gen_id;
      mem_end[wr_ptr]     <= bus.gen_end;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      cand_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (accept) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, accept})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (accept) cand_cnt <= head_end ? '0 : cand_inc;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      rpt_state    <= RptIdle;
      rpt_valid_r  <= 1'b0;
      rpt_pkt_id_r <= '0;
      rpt_num_r    <= '0;
    end else begin
      case (rpt_state)
        RptIdle: begin
          if (end_accept) begin
            rpt_state    <= RptHold;
            rpt_valid_r  <= 1'b1;
            rpt_pkt_id_r <= mem_pkt_id[rd_ptr];
            rpt_num_r    <= cand_inc;
          end
        end
        RptHold: begin
          // An end accept here implies rpt_ready, so the old report is consumed.
          if (end_accept) begin
            rpt_pkt_id_r <= mem_pkt_id[rd_ptr];
            rpt_num_r    <= cand_inc;
          end else if (bus.rpt_ready) begin
            rpt_state   <= RptIdle;
            rpt_valid_r <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_word_gen_outbuf.sv
// Self-checking bench for word_gen_outbuf: cycle tables for basic flow/backpressure,
// hand sequences for report stall, same-cycle reload, mid-run reset and saturation.
module tb_word_gen_outbuf;
  localparam int unsigned CB = 7;
  localparam int unsigned WL = 8;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 CLK = ~CLK;

  word_gen_outbuf_if #(.CHAR_BITS(CB), .WORD_MAX_LEN(WL)) bus ();

  word_gen_outbuf #(.CHAR_BITS(CB), .WORD_MAX_LEN(WL), .DEPTH(4)) dut (
    .CLK  (CLK),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] id;
    logic [15:0] pkt;
    logic        last;
  } src_t;

  typedef struct {
    logic        ordy;
    logic        rrdy;
    logic        rd;
    logic        ov;
    logic [15:0] wid;
    logic [15:0] opkt;
    logic        rv;
    logic [31:0] num;
    logic [15:0] rpkt;
  } vec_t;

  src_t src_q[$];
  int   src_idx = 0;
  vec_t vt[$];

  function automatic logic [55:0] word_of(input logic [15:0] id);
    return {id ^ 16'h5a5a, id, ~id, id[7:0]};
  endfunction

  function automatic logic [31:0] gen_of(input logic [15:0] id);
    return {16'hc0de, id};
  endfunction

  function automatic vec_t mk(input logic ordy, input logic rrdy, input logic rd,
                              input logic ov, input logic [15:0] wid, input logic [15:0] opkt,
                              input logic rv, input logic [31:0] num, input logic [15:0] rpkt);
    vec_t v;
    v.ordy = ordy; v.rrdy = rrdy; v.rd = rd; v.ov = ov; v.wid = wid; v.opkt = opkt;
    v.rv = rv; v.num = num; v.rpkt = rpkt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    if (src_idx < src_q.size()) begin
      bus.gen_empty   = 1'b0;
      bus.gen_dout    = word_of(src_q[src_idx].id);
      bus.gen_pkt_id  = src_q[src_idx].pkt;
      bus.gen_word_id = src_q[src_idx].id;
      bus.gen_id      = gen_of(src_q[src_idx].id);
      bus.gen_end     = src_q[src_idx].last;
    end else begin
      bus.gen_empty = 1'b1;
      bus.gen_end   = 1'b0;
    end
  endtask

  task automatic clear_src();
    src_q.delete();
    src_idx = 0;
  endtask

  task automatic add_src(input logic [15:0] id, input logic [15:0] pkt, input logic last);
    src_t s;
    s.id = id; s.pkt = pkt; s.last = last;
    src_q.push_back(s);
  endtask

  // Generator model: a word is consumed whenever rd_en was high across the edge.
  task automatic tick();
    logic pop;
    pop = bus.gen_rd_en;
    @(posedge CLK);
    @(negedge CLK);
    if (pop) src_idx++;
    drive_src();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    bus.rpt_ready = 1'b0;
    clear_src();
    drive_src();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_rpt(input int max_cycles, input string name);
    bit got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      if (bus.rpt_valid) got = 1'b1;
      else tick();
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: rpt_valid got 0 expected 1 within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vt.size(); i++) begin
      bus.out_ready = vt[i].ordy;
      bus.rpt_ready = vt[i].rrdy;
      #1;
      chk($sformatf("%s[%0d].gen_rd_en", name, i), 64'(bus.gen_rd_en), 64'(vt[i].rd));
      chk($sformatf("%s[%0d].out_valid", name, i), 64'(bus.out_valid), 64'(vt[i].ov));
      if (vt[i].ov) begin
        chk($sformatf("%s[%0d].out_word_id", name, i), 64'(bus.out_word_id), 64'(vt[i].wid));
        chk($sformatf("%s[%0d].out_word", name, i), 64'(bus.out_word), 64'(word_of(vt[i].wid)));
        chk($sformatf("%s[%0d].out_gen_id", name, i), 64'(bus.out_gen_id), 64'(gen_of(vt[i].wid)));
        chk($sformatf("%s[%0d].out_pkt_id", name, i), 64'(bus.out_pkt_id), 64'(vt[i].opkt));
      end
      chk($sformatf("%s[%0d].rpt_valid", name, i), 64'(bus.rpt_valid), 64'(vt[i].rv));
      if (vt[i].rv) begin
        chk($sformatf("%s[%0d].rpt_num_cand", name, i), 64'(bus.rpt_num_cand), 64'(vt[i].num));
        chk($sformatf("%s[%0d].rpt_pkt_id", name, i), 64'(bus.rpt_pkt_id), 64'(vt[i].rpkt));
      end
      tick();
    end
  endtask

  initial begin
    bus.gen_dout = '0; bus.gen_pkt_id = '0; bus.gen_word_id = '0; bus.gen_id = '0;
    bus.gen_end = 1'b0; bus.gen_empty = 1'b1; bus.out_ready = 1'b0; bus.rpt_ready = 1'b0;

    // Reset state
    do_reset();
    chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset.rpt_valid", 64'(bus.rpt_valid), 64'd0);
    chk("reset.rpt_pkt_id", 64'(bus.rpt_pkt_id), 64'd0);
    chk("reset.rpt_num_cand", 64'(bus.rpt_num_cand), 64'd0);
    chk("reset.gen_rd_en", 64'(bus.gen_rd_en), 64'd0);

    // One 3-word packet streamed straight through
    add_src(16'h0001, 16'h0011, 1'b0);
    add_src(16'h0002, 16'h0011, 1'b0);
    add_src(16'h0003, 16'h0011, 1'b1);
    drive_src();
    vt.delete();
    vt.push_back(mk(1, 0, 1, 0, 16'h0, 16'h00, 0, 0, 16'h00));
    vt.push_back(mk(1, 0, 1, 1, 16'h1, 16'h11, 0, 0, 16'h00));
    vt.push_back(mk(1, 0, 1, 1, 16'h2, 16'h11, 0, 0, 16'h00));
    vt.push_back(mk(1, 0, 0, 1, 16'h3, 16'h11, 0, 0, 16'h00));
    vt.push_back(mk(1, 0, 0, 0, 16'h0, 16'h00, 1, 3, 16'h11));
    vt.push_back(mk(1, 1, 0, 0, 16'h0, 16'h00, 1, 3, 16'h11));
    vt.push_back(mk(1, 0, 0, 0, 16'h0, 16'h00, 0, 0, 16'h00));
    run_table("flow");

    // Backpressure: FIFO fills to DEPTH, head frozen, then drains in order
    do_reset();
    for (int i = 0; i < 6; i++) add_src(16'(16'h21 + i), 16'h0022, 1'b0);
    drive_src();
    vt.delete();
    vt.push_back(mk(0, 0, 1, 0, 16'h00, 16'h00, 0, 0, 16'h0));
    vt.push_back(mk(0, 0, 1, 1, 16'h21, 16'h22, 0, 0, 16'h0));
    vt.push_back(mk(0, 0, 1, 1, 16'h21, 16'h22, 0, 0, 16'h0));
    vt.push_back(mk(0, 0, 1, 1, 16'h21, 16'h22, 0, 0, 16'h0));
    vt.push_back(mk(0, 0, 0, 1, 16'h21, 16'h22, 0, 0, 16'h0));
    vt.push_back(mk(1, 0, 0, 1, 16'h21, 16'h22, 0, 0, 16'h0));
    vt.push_back(mk(1, 0, 1, 1, 16'h22, 16'h22, 0, 0, 16'h0));
    vt.push_back(mk(1, 0, 1, 1, 16'h23, 16'h22, 0, 0, 16'h0));
    vt.push_back(mk(1, 0, 0, 1, 16'h24, 16'h22, 0, 0, 16'h0));
    vt.push_back(mk(1, 0, 0, 1, 16'h25, 16'h22, 0, 0, 16'h0));
    vt.push_back(mk(1, 0, 0, 1, 16'h26, 16'h22, 0, 0, 16'h0));
    vt.push_back(mk(1, 0, 0, 0, 16'h00, 16'h00, 0, 0, 16'h0));
    run_table("bp");

    // Two packets with the report held: second end word stalls
    do_reset();
    add_src(16'h0031, 16'h0031, 1'b0);
    add_src(16'h0032, 16'h0031, 1'b1);
    add_src(16'h0033, 16'h0033, 1'b1);
    bus.out_ready = 1'b1;
    drive_src();
    #1;
    wait_rpt(20, "two_pkt.rpt1");
    chk("two_pkt.rpt1_num", 64'(bus.rpt_num_cand), 64'd2);
    chk("two_pkt.rpt1_pkt", 64'(bus.rpt_pkt_id), 64'h31);
    for (int i = 0; i < 3; i++) tick();
    chk("two_pkt.stall_out_valid", 64'(bus.out_valid), 64'd0);
    chk("two_pkt.stall_head", 64'(bus.out_word_id), 64'h33);
    chk("two_pkt.rpt1_hold", 64'(bus.rpt_num_cand), 64'd2);

    // Report taken in the same cycle the next end word is accepted
    bus.rpt_ready = 1'b1;
    #1;
    chk("reload.out_valid", 64'(bus.out_valid), 64'd1);
    tick();
    bus.rpt_ready = 1'b0;
    #1;
    chk("reload.rpt_valid", 64'(bus.rpt_valid), 64'd1);
    chk("reload.rpt_num", 64'(bus.rpt_num_cand), 64'd1);
    chk("reload.rpt_pkt", 64'(bus.rpt_pkt_id), 64'h33);
    tick();
    chk("reload.hold", 64'(bus.rpt_pkt_id), 64'h33);
    bus.rpt_ready = 1'b1;
    tick();
    bus.rpt_ready = 1'b0;
    #1;
    chk("reload.taken", 64'(bus.rpt_valid), 64'd0);

    // Mid-run reset with 3 words buffered and a report pending
    do_reset();
    add_src(16'h0051, 16'h0051, 1'b1);
    add_src(16'h0052, 16'h0057, 1'b0);
    add_src(16'h0053, 16'h0057, 1'b1);
    add_src(16'h0054, 16'h0057, 1'b0);
    add_src(16'h0055, 16'h0057, 1'b0);
    bus.out_ready = 1'b1;
    drive_src();
    #1;
    for (int i = 0; i < 12; i++) tick();
    chk("midrst.pre_rpt_valid", 64'(bus.rpt_valid), 64'd1);
    chk("midrst.pre_rpt_num", 64'(bus.rpt_num_cand), 64'd1);
    chk("midrst.pre_stall", 64'(bus.out_valid), 64'd0);
    chk("midrst.pre_head", 64'(bus.out_word_id), 64'h53);
    clear_src();
    add_src(16'h0058, 16'h0058, 1'b1);
    rst_n = 1'b0;
    drive_src();
    #1;
    chk("midrst.rd_en_in_reset", 64'(bus.gen_rd_en), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst.rpt_valid", 64'(bus.rpt_valid), 64'd0);
    chk("midrst.rpt_num", 64'(bus.rpt_num_cand), 64'd0);
    chk("midrst.rd_en", 64'(bus.gen_rd_en), 64'd1);
    wait_rpt(20, "midrst.rpt");
    chk("midrst.new_num", 64'(bus.rpt_num_cand), 64'd1);
    chk("midrst.new_pkt", 64'(bus.rpt_pkt_id), 64'h58);

    // Candidate counter saturation
    do_reset();
    force dut.cand_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.cand_cnt;
    add_src(16'h0061, 16'h0061, 1'b0);
    add_src(16'h0062, 16'h0061, 1'b0);
    add_src(16'h0063, 16'h0061, 1'b1);
    bus.out_ready = 1'b1;
    drive_src();
    #1;
    wait_rpt(20, "sat.rpt");
    chk("sat.num", 64'(bus.rpt_num_cand), 64'hFFFF_FFFF);
    chk("sat.pkt", 64'(bus.rpt_pkt_id), 64'h61);
    bus.rpt_ready = 1'b1;
    tick();
    bus.rpt_ready = 1'b0;
    clear_src();
    add_src(16'h0064, 16'h0064, 1'b1);
    drive_src();
    #1;
    wait_rpt(20, "sat.after");
    chk("sat.after_num", 64'(bus.rpt_num_cand), 64'd1);
    chk("sat.after_pkt", 64'(bus.rpt_pkt_id), 64'h64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
